nios_security_input_pio: RTL and testbench

Avalon-MM slave input port for the nios_security Nios II system. It is the read-side counterpart of the LED output PIO. It samples external inputs (switches, buttons, S.BUS status lines) through a synchronizer and an optional debouncer. It exposes the filtered level, a per-bit edge-capture register and a maskable interrupt to the CPU.

---
 rtl/nios_security_input_pio.sv | 110 +++++++++++
 tb/tb_nios_security_input_pio.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nios_security_input_pio.sv
// nios_security_input_pio: Avalon-MM input PIO with synchronizer, optional debounce, edge capture and maskable irq.
//
// Ports:
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   address    register select (0 DATA, 1 reserved, 2 IRQMASK, 3 EDGECAP)
//   chipselect slave select
//   write_n    active-low write strobe
//   writedata  write data
//   in_port    asynchronous external inputs
//   readdata   registered read data, valid the cycle after a read
//   irq        level interrupt, |(EDGECAP & IRQMASK)
//
// Build option: define NIOS_SECURITY_INPUT_PIO_DEBOUNCE_EN to insert the
// prescaler-based debouncer between the synchronizer and the stable level.
module nios_security_input_pio #(
    parameter int WIDTH           = 8,
    parameter int EDGE_TYPE       = 0,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);
    logic [WIDTH-1:0] sync1, sync2, stable, stable_nx, load_mask;
    logic [WIDTH-1:0] irq_mask, edge_cap, edges, det, clr;
    logic [31:0]      rd_mux;
    logic             wr, rd, det_en;
    logic             unused_wd;

    assign wr        = chipselect && !write_n;
    assign rd        = chipselect && write_n;
    assign unused_wd = ^writedata;

`ifdef NIOS_SECURITY_INPUT_PIO_DEBOUNCE_EN
    localparam int PW = $clog2(DEBOUNCE_CYCLES);
    logic [PW-1:0]    presc;
    logic [WIDTH-1:0] samp;
    logic             primed, tick;

    assign tick = presc == PW'(DEBOUNCE_CYCLES - 1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc  <= '0;
            samp   <= '0;
            primed <= 1'b0;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick) begin
                samp   <= sync2;
                primed <= 1'b1;
            end
        end
    end

    // The first tick loads the whole sampled level with edges suppressed;
    // later ticks only load bits that agreed with the previous tick's sample.
    assign load_mask = !tick ? '0 : primed ? ~(sync2 ^ samp) : '1;
    assign det_en    = primed;
`else
    localparam int unused_dc = DEBOUNCE_CYCLES;
    logic [1:0] init_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) init_cnt <= '0;
        else          init_cnt <= init_cnt + {1'b0, init_cnt != 2'd3};
    end

    // Edges are ignored until the synchronizer has delivered the first real
    // input sample into stable, so a level present at reset is not an edge.
    assign load_mask = '1;
    assign det_en    = init_cnt == 2'd3;
`endif

    assign stable_nx = (stable & ~load_mask) | (sync2 & load_mask);
    assign edges     = EDGE_TYPE == 0 ? (stable_nx & ~stable) :
                       EDGE_TYPE == 1 ? (~stable_nx & stable) : (stable_nx ^ stable);
    assign det       = det_en ? edges : '0;
    assign clr       = (wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
    assign rd_mux    = address == 2'd0 ? 32'(stable) :
                       address == 2'd2 ? 32'(irq_mask) :
                       address == 2'd3 ? 32'(edge_cap) : '0;
    assign irq       = |(edge_cap & irq_mask);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1    <= '0;
            sync2    <= '0;
            stable   <= '0;
            irq_mask <= '0;
            edge_cap <= '0;
            readdata <= '0;
        end else begin
            sync1    <= in_port;
            sync2    <= sync1;
            stable   <= stable_nx;
            // Set wins over a simultaneous write-1-to-clear.
            edge_cap <= (edge_cap & ~clr) | det;
            if (wr && address == 2'd2) irq_mask <= writedata[WIDTH-1:0];
            if (rd) readdata <= rd_mux;
        end
    end
endmodule

// File: tb/tb_nios_security_input_pio.sv
// tb_nios_security_input_pio: self-checking bench for nios_security_input_pio (rising and any-edge instances).
module tb_nios_security_input_pio;
    localparam int W = 8;

    typedef struct {
        bit          w;
        logic [1:0]  a;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           chipselect = 1'b0;
    logic           write_n = 1'b1;
    logic [1:0]     address = 2'd0;
    logic [31:0]    writedata = 32'd0;
    logic [W-1:0]   in_port = '0;
    logic [31:0]    rd_r, rd_a;
    logic           irq_r, irq_a;
    int             checks = 0;
    int             failures = 0;
    bit             use_model;

    logic [W-1:0]   q[$];
    logic [W-1:0]   m_stable, m_mask, m_cap_r, m_cap_a;
    logic [31:0]    m_rd_r, m_rd_a;
    int             m_edges;
    vec_t           tbl[10];

    always #5 clk = ~clk;

    nios_security_input_pio #(.WIDTH(W), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(16)) u_rise (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd_r), .irq(irq_r));

    nios_security_input_pio #(.WIDTH(W), .EDGE_TYPE(2), .DEBOUNCE_CYCLES(16)) u_any (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd_a), .irq(irq_a));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] m_reg(input logic [1:0] a, input logic [W-1:0] cap);
        if (a == 2'd0) return 32'(m_stable);
        if (a == 2'd2) return 32'(m_mask);
        if (a == 2'd3) return 32'(cap);
        return 32'd0;
    endfunction

    task automatic model_reset();
        q = {};
        m_stable = '0;
        m_mask = '0;
        m_cap_r = '0;
        m_cap_a = '0;
        m_rd_r = 32'd0;
        m_rd_a = 32'd0;
        m_edges = 0;
    endtask

    // Level seen by software is the input from two edges back; edges count
    // only once that delay line holds genuine post-reset samples.
    task automatic model_edge();
        logic [W-1:0] nxt, clr;
        if (chipselect && write_n) begin
            m_rd_r = m_reg(address, m_cap_r);
            m_rd_a = m_reg(address, m_cap_a);
        end
        m_edges++;
        q.push_back(in_port);
        if (q.size() > 3) void'(q.pop_front());
        nxt = (q.size() == 3) ? q[0] : '0;
        clr = (chipselect && !write_n && address == 2'd3) ? writedata[W-1:0] : '0;
        m_cap_r = (m_cap_r & ~clr) | ((m_edges >= 4) ? (nxt & ~m_stable) : '0);
        m_cap_a = (m_cap_a & ~clr) | ((m_edges >= 4) ? (nxt ^ m_stable) : '0);
        if (chipselect && !write_n && address == 2'd2) m_mask = writedata[W-1:0];
        m_stable = nxt;
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset_n) model_reset();
        else if (use_model) model_edge();
        @(negedge clk);
        if (use_model) begin
            check("irq_r model", 32'(irq_r), 32'(|(m_cap_r & m_mask)));
            check("irq_a model", 32'(irq_a), 32'(|(m_cap_a & m_mask)));
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write_n = 1'b0;
        address = a;
        writedata = d;
        tick();
        chipselect = 1'b0;
        write_n = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a);
        chipselect = 1'b1;
        write_n = 1'b1;
        address = a;
        tick();
        chipselect = 1'b0;
        if (use_model) begin
            check("rd_r model", rd_r, m_rd_r);
            check("rd_a model", rd_a, m_rd_a);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        repeat (3) tick();
        reset_n = 1'b1;
    endtask

    task automatic mid_reset();
        #2 reset_n = 1'b0;
        #1;
        check("async reset irq_r", 32'(irq_r), 32'd0);
        check("async reset irq_a", 32'(irq_a), 32'd0);
        check("async reset readdata", rd_r, 32'd0);
        model_reset();
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        rd(2'd2);
        check("irqmask after reset", rd_r, 32'd0);
        rd(2'd3);
        check("edgecap after reset", rd_r, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
`ifdef NIOS_SECURITY_INPUT_PIO_DEBOUNCE_EN
        use_model = 1'b0;
`else
        use_model = 1'b1;
`endif
        model_reset();
        in_port = '1;
        @(negedge clk);
        check("reset readdata", rd_r, 32'd0);
        check("reset irq", 32'(irq_r), 32'd0);
        do_reset();
        repeat (use_model ? 10 : 40) tick();
        rd(2'd0);
        check("data after reset r", rd_r, 32'hFF);
        check("data after reset a", rd_a, 32'hFF);
        rd(2'd3);
        check("no spurious edge r", rd_r, 32'd0);
        check("no spurious edge a", rd_a, 32'd0);
        check("irq after reset", 32'(irq_r), 32'd0);

`ifndef NIOS_SECURITY_INPUT_PIO_DEBOUNCE_EN
        in_port = '0;
        repeat (5) tick();
        wr(2'd3, 32'hFF);
        wr(2'd2, 32'h01);
        in_port = 8'h01;
        tick();
        tick();
        check("irq before k+2", 32'(irq_r), 32'd0);
        tick();
        check("irq_r at k+2", 32'(irq_r), 32'd1);
        check("irq_a at k+2", 32'(irq_a), 32'd1);
        rd(2'd3);
        check("edgecap bit0", rd_r, 32'h01);
        wr(2'd3, 32'h01);
        check("irq_r cleared", 32'(irq_r), 32'd0);
        check("irq_a cleared", 32'(irq_a), 32'd0);

        in_port = 8'h09;
        tick();
        tick();
        wr(2'd3, 32'h08);
        rd(2'd3);
        check("collision r", rd_r, 32'h08);
        check("collision a", rd_a, 32'h08);

        wr(2'd2, 32'h0);
        wr(2'd3, 32'hFF);
        in_port = 8'h0D;
        repeat (4) tick();
        in_port = 8'h09;
        repeat (4) tick();
        rd(2'd3);
        check("any-edge cap", rd_a, 32'h04);
        check("rise cap", rd_r, 32'h04);
        check("masked irq_a", 32'(irq_a), 32'd0);
        wr(2'd2, 32'h04);
        check("unmask irq_a", 32'(irq_a), 32'd1);

        tbl = '{'{1'b1, 2'd2, 32'h000000A5, 32'h0},
                '{1'b0, 2'd2, 32'h0,        32'h000000A5},
                '{1'b1, 2'd1, 32'hFFFFFFFF, 32'h0},
                '{1'b0, 2'd1, 32'h0,        32'h0},
                '{1'b1, 2'd2, 32'hFFFFFF3C, 32'h0},
                '{1'b0, 2'd2, 32'h0,        32'h0000003C},
                '{1'b0, 2'd0, 32'h0,        32'h00000009},
                '{1'b1, 2'd0, 32'h000000FF, 32'h0},
                '{1'b0, 2'd0, 32'h0,        32'h00000009},
                '{1'b0, 2'd3, 32'h0,        32'h00000004}};
        for (int i = 0; i < 10; i++) begin
            if (tbl[i].w) wr(tbl[i].a, tbl[i].d);
            else begin
                rd(tbl[i].a);
                check($sformatf("table %0d r", i), rd_r, tbl[i].exp);
                check($sformatf("table %0d a", i), rd_a, tbl[i].exp);
            end
        end

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(3) == 0) in_port = W'($urandom);
            case ($urandom_range(2))
                0: tick();
                1: rd(2'($urandom));
                default: wr(2'($urandom), $urandom);
            endcase
        end

        wr(2'd2, 32'h0F);
        in_port = '0;
        repeat (5) tick();
        wr(2'd3, 32'hFF);
        in_port = 8'h0F;
        repeat (5) tick();
        rd(2'd3);
        check("pre-reset cap", rd_r, 32'h0F);
        check("pre-reset irq", 32'(irq_r), 32'd1);
        mid_reset();
`else
        in_port = '0;
        repeat (50) tick();
        wr(2'd3, 32'hFF);
        rd(2'd0);
        check("db settle low", rd_r, 32'h0);
        in_port = 8'h02;
        repeat (10) tick();
        in_port = '0;
        repeat (40) tick();
        rd(2'd0);
        check("glitch data r", rd_r, 32'h0);
        check("glitch data a", rd_a, 32'h0);
        rd(2'd3);
        check("glitch cap r", rd_r, 32'h0);
        check("glitch cap a", rd_a, 32'h0);
        in_port = 8'h02;
        chipselect = 1'b1;
        write_n = 1'b1;
        address = 2'd0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (rd_r[1] && n == 0) n = i + 1;
        end
        chipselect = 1'b0;
        check("db latency window", 32'(n >= 20 && n <= 36), 32'd1);
        rd(2'd3);
        check("db cap r", rd_r, 32'h02);
        check("db cap a", rd_a, 32'h02);
        wr(2'd2, 32'h0F);
        in_port = 8'h0F;
        repeat (50) tick();
        rd(2'd3);
        check("pre-reset cap r", rd_r, 32'h0F);
        check("pre-reset cap a", rd_a, 32'h0F);
        check("pre-reset irq", 32'(irq_r), 32'd1);
        repeat (5) tick();
        mid_reset();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
